// File: rtl/mapper_mmc_if.sv
// Bus bundle between the host (CPU/PPU side) and the cartridge mapper.
// The master drives header fields, CPU writes and fetch addresses; the slave returns translations.
interface mapper_mmc_if #(
   parameter int unsigned PRG_W = 4,
   parameter int unsigned CHR_W = 5
);
   logic [7:0]          num;
   logic [PRG_W-1:0]    max;
   logic                hdr_v;
   logic                ct_cpu;
   logic [15:0]         cpu_a;
   logic [7:0]          cpu_o;
   logic                cpu_w;
   logic [15:0]         program_a;
   logic [12:0]         chr_a;
   logic [PRG_W+13:0]   program_m;
   logic [CHR_W+11:0]   chr_m;
   logic [1:0]          mirror;
   logic                cw;
   logic                wram_en;

   modport master (
      output num, max, hdr_v, ct_cpu, cpu_a, cpu_o, cpu_w, program_a, chr_a,
      input  program_m, chr_m, mirror, cw, wram_en
   );

   modport slave (
      input  num, max, hdr_v, ct_cpu, cpu_a, cpu_o, cpu_w, program_a, chr_a,
      output program_m, chr_m, mirror, cw, wram_en
   );
endinterface

// File: rtl/mapper_mmc.sv
// Cartridge address mapper for NROM (0), MMC1 (1) and UxROM (2).
// Holds bank registers and translates PRG/CHR addresses combinationally.
module mapper_mmc #(
   parameter int unsigned PRG_W = 4,
   parameter int unsigned CHR_W = 5
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   mapper_mmc_if.slave  bus
);

   logic [4:0]       r_shift;
   logic [4:0]       r_ctrl;
   logic [4:0]       r_chr0;
   logic [4:0]       r_chr1;
   logic [4:0]       r_prg;
   logic [PRG_W-1:0] r_ubank;
   logic             r_prev_wr;

   logic             w_wr;
   logic             w_is_mmc1;
   logic             w_is_uxrom;
   logic [4:0]       w_shift_nxt;
   logic [4:0]       w_pb_full;
   logic [PRG_W-1:0] w_pb;
   logic [PRG_W-1:0] w_prg_bank;
   logic [CHR_W-1:0] w_chr_bank;
   logic             w_a14;
   logic             w_a12;
   logic             w_unused;

   assign w_wr        = bus.ct_cpu & bus.cpu_w & bus.cpu_a[15];
   assign w_is_mmc1   = (bus.num == 8'd1);
   assign w_is_uxrom  = (bus.num == 8'd2);
   assign w_shift_nxt = {bus.cpu_o[0], r_shift[4:1]};
   assign w_pb_full   = {r_chr0[4], r_prg[3:0]};
   assign w_pb        = w_pb_full[PRG_W-1:0];
   assign w_a14       = bus.program_a[14];
   assign w_a12       = bus.chr_a[12];

   // Bits of wide inputs/registers that narrow bank parameters leave unread.
   assign w_unused = ^{bus.cpu_o, bus.cpu_a, bus.program_a, r_chr0, r_chr1};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift   <= 5'b10000;
         r_ctrl    <= 5'h0C;
         r_chr0    <= 5'h00;
         r_chr1    <= 5'h00;
         r_prg     <= 5'h00;
         r_ubank   <= '0;
         r_prev_wr <= 1'b0;
      end else begin
         if (bus.ct_cpu) begin
            r_prev_wr <= w_wr;
         end
         // A write straight after another write is the dummy cycle of a RMW; drop it.
         if (w_wr && w_is_mmc1 && !r_prev_wr) begin
            if (bus.cpu_o[7]) begin
               r_shift <= 5'b10000;
               r_ctrl  <= r_ctrl | 5'h0C;
            end else if (!r_shift[0]) begin
               r_shift <= w_shift_nxt;
            end else begin
               r_shift <= 5'b10000;
               unique case (bus.cpu_a[14:13])
                  2'd0:    r_ctrl <= w_shift_nxt;
                  2'd1:    r_chr0 <= w_shift_nxt;
                  2'd2:    r_chr1 <= w_shift_nxt;
                  default: r_prg  <= w_shift_nxt;
               endcase
            end
         end
         if (w_wr && w_is_uxrom) begin
            r_ubank <= bus.cpu_o[PRG_W-1:0];
         end
      end
   end

   always_comb begin
      w_prg_bank  = '0;
      w_chr_bank  = '0;
      bus.mirror  = bus.hdr_v ? 2'd2 : 2'd3;
      bus.cw      = 1'b0;
      bus.wram_en = 1'b1;
      if (w_is_mmc1) begin
         unique case (r_ctrl[3:2])
            2'd2:    w_prg_bank = w_a14 ? w_pb : '0;
            2'd3:    w_prg_bank = w_a14 ? bus.max : w_pb;
            default: begin
               w_prg_bank    = w_pb;
               w_prg_bank[0] = w_a14;
            end
         endcase
         if (r_ctrl[4]) begin
            w_chr_bank = w_a12 ? r_chr1[CHR_W-1:0] : r_chr0[CHR_W-1:0];
         end else begin
            w_chr_bank    = r_chr0[CHR_W-1:0];
            w_chr_bank[0] = w_a12;
         end
         bus.mirror  = r_ctrl[1:0];
         bus.wram_en = ~r_prg[4];
      end else if (w_is_uxrom) begin
         w_prg_bank    = w_a14 ? bus.max : r_ubank;
         w_chr_bank[0] = w_a12;
         bus.cw        = 1'b1;
      end else begin
         // A single 16K image mirrors into $C000.
         w_prg_bank[0] = w_a14 & (bus.max != '0);
         w_chr_bank[0] = w_a12;
      end
   end

   assign bus.program_m = {w_prg_bank, bus.program_a[13:0]};
   assign bus.chr_m     = {w_chr_bank, bus.chr_a[11:0]};

endmodule

// File: tb/tb_mapper_mmc.sv
// Scoreboard bench for mapper_mmc: stimulus pushes model predictions, a negedge monitor compares.
module tb_mapper_mmc;
   localparam int unsigned PW = 4;
   localparam int unsigned CW = 5;

   typedef struct {
      logic [PW+13:0] pm;
      logic [CW+11:0] cm;
      logic [1:0]     mir;
      logic           cw;
      logic           wram;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   mapper_mmc_if #(.PRG_W(PW), .CHR_W(CW)) bus ();

   mapper_mmc #(.PRG_W(PW), .CHR_W(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_pass = 0;

   // Model: MMC1 serial port as a bit counter plus accumulated value (LSB first).
   int m_ctrl, m_chr0, m_chr1, m_prg, m_ubank, m_cnt, m_val, m_prev;

   task automatic model_reset();
      m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_ubank = 0;
      m_cnt = 0; m_val = 0; m_prev = 0;
   endtask

   function automatic exp_t model_out();
      exp_t r;
      int pa, ca, a14, a12, mx, pbank, cbank, pb;
      pa = int'(bus.program_a); ca = int'(bus.chr_a);
      a14 = (pa >> 14) & 1; a12 = (ca >> 12) & 1; mx = int'(bus.max);
      r.mir = bus.hdr_v ? 2'd2 : 2'd3; r.cw = 1'b0; r.wram = 1'b1;
      pbank = 0; cbank = a12;
      if (bus.num == 8'd1) begin
         pb = ((((m_chr0 >> 4) & 1) * 16) + (m_prg % 16)) % (1 << PW);
         case ((m_ctrl / 4) % 4)
            2:       pbank = a14 ? pb : 0;
            3:       pbank = a14 ? mx : pb;
            default: pbank = (pb / 2) * 2 + a14;
         endcase
         if ((m_ctrl / 16) % 2 == 1) cbank = (a12 ? m_chr1 : m_chr0) % (1 << CW);
         else                        cbank = ((m_chr0 % (1 << CW)) / 2) * 2 + a12;
         r.mir = 2'(m_ctrl % 4);
         r.wram = ((m_prg / 16) % 2) == 0;
      end else if (bus.num == 8'd2) begin
         pbank = a14 ? mx : m_ubank;
         r.cw = 1'b1;
      end else begin
         pbank = (a14 == 1 && mx != 0) ? 1 : 0;
      end
      r.pm = (PW + 14)'(pbank * 16384 + (pa % 16384));
      r.cm = (CW + 12)'(cbank * 4096 + (ca % 4096));
      return r;
   endfunction

   task automatic model_step();
      int wr, d;
      wr = (bus.ct_cpu && bus.cpu_w && bus.cpu_a[15]) ? 1 : 0;
      d = int'(bus.cpu_o);
      if (bus.num == 8'd1 && wr == 1 && m_prev == 0) begin
         if (d >= 128) begin
            m_cnt = 0; m_val = 0; m_ctrl = m_ctrl | 12;
         end else begin
            m_val = m_val + (d % 2) * (1 << m_cnt);
            m_cnt++;
            if (m_cnt == 5) begin
               case (int'(bus.cpu_a[14:13]))
                  0: m_ctrl = m_val;
                  1: m_chr0 = m_val;
                  2: m_chr1 = m_val;
                  default: m_prg = m_val;
               endcase
               m_cnt = 0; m_val = 0;
            end
         end
      end
      if (bus.num == 8'd2 && wr == 1) m_ubank = d % (1 << PW);
      if (bus.ct_cpu) m_prev = wr;
   endtask

   // Called just after a rising edge: drive one cycle, predict, advance the model at the edge.
   task automatic cyc(input bit ct, input bit w, input logic [15:0] a, input logic [7:0] d,
                      input logic [15:0] pa, input logic [12:0] ca);
      bus.ct_cpu = ct; bus.cpu_w = w; bus.cpu_a = a; bus.cpu_o = d;
      bus.program_a = pa; bus.chr_a = ca;
      q.push_back(model_out());
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic mmc_wr(input logic [15:0] a, input logic [7:0] d);
      cyc(1'b1, 1'b1, a, d, 16'h8000, 13'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 8'h00, 16'hC000, 13'h1000);
   endtask

   task automatic mmc_load(input logic [15:0] a, input int v);
      for (int i = 0; i < 5; i++) mmc_wr(a, 8'((v >> i) & 1));
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("program_m", 32'(bus.program_m), 32'(e.pm));
         chk("chr_m", 32'(bus.chr_m), 32'(e.cm));
         chk("mirror", 32'(bus.mirror), 32'(e.mir));
         chk("cw", 32'(bus.cw), 32'(e.cw));
         chk("wram_en", 32'(bus.wram_en), 32'(e.wram));
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      bus.num = 8'd1; bus.max = 4'd7; bus.hdr_v = 1'b0;
      bus.ct_cpu = 1'b0; bus.cpu_w = 1'b0; bus.cpu_a = '0; bus.cpu_o = '0;
      bus.program_a = '0; bus.chr_a = '0;
      @(posedge clk); #1;
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'hC123, 13'h0000);   // held in reset
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'hC123, 13'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0123);
      // PRG bank 5 via five serial writes, LSB first.
      mmc_load(16'hE000, 5);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8004, 13'h0000);
      // Partial load aborted by a $80 write, then a clean load of 6.
      mmc_wr(16'hE000, 8'h01); mmc_wr(16'hE000, 8'h01); mmc_wr(16'hE000, 8'h80);
      mmc_load(16'hE000, 6);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8004, 13'h0000);
      // Back-to-back strobed writes: the second must be dropped.
      cyc(1'b1, 1'b1, 16'hE000, 8'h01, 16'h8000, 13'h0000);
      cyc(1'b1, 1'b1, 16'hE000, 8'h01, 16'h8000, 13'h0000);
      cyc(1'b1, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0000);
      for (int i = 0; i < 4; i++) mmc_wr(16'hE000, 8'h00);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0000);
      // CHR banking, 4K then 8K mode.
      mmc_load(16'h8000, 16'h10); mmc_load(16'hA000, 3); mmc_load(16'hC000, 6);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h1010);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0010);
      mmc_load(16'h8000, 0);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0010);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h1010);
      // UxROM, then asynchronous reset mid-run.
      bus.num = 8'd2; bus.hdr_v = 1'b1;
      cyc(1'b1, 1'b1, 16'h8000, 8'h03, 16'h8000, 13'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h1FFF);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'hC000, 13'h0000);
      cyc(1'b1, 1'b1, 16'h7000, 8'h05, 16'h8000, 13'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0000);
      rst_n = 1'b0;
      model_reset();
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 16'h8000, 13'h0000);
      rst_n = 1'b1;
      // Randomized traffic across mapper numbers and bank limits.
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 4))
               0: bus.num = 8'd0;
               1, 2: bus.num = 8'd1;
               3: bus.num = 8'd2;
               default: bus.num = 8'd5;
            endcase
            bus.max = 4'($urandom_range(0, 15));
            bus.hdr_v = 1'($urandom_range(0, 1));
         end
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom) | ($urandom_range(0, 3) != 0 ? 16'h8000 : 16'h0000),
             ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom_range(0, 127)),
             16'($urandom), 13'($urandom));
      end
      @(negedge clk); #1;
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mapper_mmc.md
# mapper_mmc

Cartridge address mapper, successor to the fixed NROM/UxROM mapper. Sits between the CPU/PPU buses and cartridge ROM/RAM. Translates CPU PRG addresses and PPU CHR addresses into physical ROM offsets, and drives nametable mirroring, CHR-RAM write enable and PRG-RAM enable. Supports mapper 0 (NROM), 1 (MMC1, with a serial load register) and 2 (UxROM), with parametrised bank widths.

## Interface
- PRG_W, 4: PRG 16K bank-number width, 1..5.
- CHR_W, 5: CHR 4K bank-number width, 1..5.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- num  in  8  mapper number from the iNES header.
- max  in  PRG_W  index of the last 16K PRG bank.
- hdr_v  in  1  header mirroring bit (1 = vertical). Used in NROM and UxROM modes.
- ct_cpu  in  1  one-clock strobe marking the CPU bus-cycle edge.
- cpu_a  in  16  CPU write address.
- cpu_o  in  8  CPU write data.
- cpu_w  in  1  CPU write.
- program_a  in  16  CPU fetch address to translate.
- chr_a  in  13  PPU pattern address to translate.
- program_m  out  PRG_W+14  physical PRG offset.
- chr_m  out  CHR_W+12  physical CHR offset.
- mirror  out  2  nametable mode: 0 = one-screen A, 1 = one-screen B, 2 = vertical, 3 = horizontal.
- cw  out  1  CHR is writable (CHR-RAM).
- wram_en  out  1  PRG-RAM at $6000-$7FFF is enabled.

## Operation
- Register write event (wr): ct_cpu & cpu_w & cpu_a[15].
- State registers and their reset values:
  - shift[4:0] = 5'b10000 (a single 1 acts as the end marker).
  - ctrl[4:0] = 5'h0C.
  - chr0 = chr1 = prg = 5'h00.
  - ubank = 0.
  - prev_wr = 0.
- prev_wr is updated on every ct_cpu strobe to the wr value of that strobe.
- Mapper 1 (MMC1):
  - If wr and prev_wr=1, the write is ignored. This models the dropped second write of a read-modify-write instruction.
  - Otherwise, on wr with cpu_o[7]=1:
    - shift <= 5'b10000.
    - ctrl <= ctrl | 5'h0C.
  - Otherwise, on wr with cpu_o[7]=0 and shift[0]=0: shift <= {cpu_o[0], shift[4:1]}.
  - Otherwise, on wr with cpu_o[7]=0 and shift[0]=1 (fifth bit), the value {cpu_o[0], shift[4:1]} is written to the register selected by cpu_a[14:13]:
    - 0 = ctrl.
    - 1 = chr0.
    - 2 = chr1.
    - 3 = prg.
    - shift <= 5'b10000 in the same cycle.
  - Effective PRG bank pb = {chr0[4], prg[3:0]}, truncated to PRG_W.
  - PRG translation by ctrl[3:2]:
    - 0 or 1: 32K mode, bank {pb[PRG_W-1:1], program_a[14]}.
    - 2: $8000 fixed to bank 0, $C000 = pb.
    - 3: $8000 = pb, $C000 fixed to max.
  - CHR translation by ctrl[4]:
    - 0: 8K mode, bank {chr0[CHR_W-1:1], chr_a[12]}.
    - 1: chr_a[12] selects chr0 or chr1.
  - Outputs: mirror = ctrl[1:0]; wram_en = ~prg[4]; cw = 0.
- Mapper 2 (UxROM):
  - wr (no consecutive-write filter): ubank <= cpu_o[PRG_W-1:0].
  - program_m = {program_a[14] ? max : ubank, program_a[13:0]}.
  - chr_m = chr_a zero-extended.
  - cw = 1; mirror = hdr_v ? 2 : 3; wram_en = 1.
- Mapper 0 and any other number (NROM):
  - program_m = {program_a[14] & (max != 0), program_a[13:0]} zero-extended. A 16K image therefore mirrors.
  - chr_m = chr_a zero-extended; cw = 0; mirror as in UxROM; wram_en = 1.
- Width rules: bank numbers are truncated to their parameter width, never saturated. Offsets are zero-extended.

## Timing
- All state updates happen on the clock edge at which the qualifying strobe is present. The new mapping is visible combinationally from the following cycle.
- All outputs are combinational from registered state plus program_a / chr_a, with zero-cycle translation latency.
- Reset is asynchronous and affects all state, including mid-sequence. On reset release in MMC1 mode:
  - $C000-$FFFF maps to bank max.
  - $8000-$BFFF maps to bank 0.
  - mirror = 0; wram_en = 1.
- If num changes while running, the registers hold their values and the translation follows the new num immediately.
- A write with cpu_a[15]=0 never touches mapper state.

## Test plan
- MMC1 after reset, program_a=$C123, max=7 -> program_m = {3'd7, 14'h0123}; program_a=$8000 -> bank 0; mirror=0.
- MMC1: five writes to $E000 with data bit0 = 1,0,1,0,0 on non-consecutive CPU cycles -> prg=5; program_a=$8004 -> program_m = {4'd5, 14'h0004}. shift returns to 5'b10000 after the fifth write.
- MMC1: two writes, then a write of $80 -> shift = 5'b10000, ctrl = $0C. The following five-write sequence loads its register correctly.
- MMC1: two writes on consecutive ct_cpu strobes -> the second write is ignored and the shift register advances only one bit.
- MMC1: ctrl=$10 (4K CHR), chr0=3, chr1=6 -> chr_a=$1010 gives chr_m = {5'd6, 12'h010}; ctrl=$00 with chr0=3 -> chr_a=$0010 gives {5'd2, 12'h010}.
- UxROM: write $03 to $8000, max=7 -> $8000 maps to bank 3, $C000 maps to bank 7, cw=1. Asserting reset_n=0 mid-run returns bank 0 asynchronously.
